// File: rtl/regfile_pkg.sv
// Shared constants and types for the datapath register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_NUM_RD = 2;

  typedef logic [$clog2(REGFILE_DEPTH)-1:0] reg_idx_t;

  // Architectural zero register (XZR) for the default 32-entry file.
  localparam reg_idx_t XZR_IDX = reg_idx_t'(REGFILE_DEPTH - 1);

endpackage

// File: rtl/regfile_read_mux.sv
// DEPTH:1 selector of WIDTH-bit words, one instance per register file read port.
module read_mux
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0]  i_regs [DEPTH],
  input  logic [ADDR_W-1:0] i_sel,
  output logic [WIDTH-1:0]  o_data
);

  always_comb begin
    o_data = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (i_sel == ADDR_W'(d)) begin
        o_data = i_regs[d];
      end
    end
  end

endmodule

// File: rtl/regfile_nr1w.sv
// N-read / 1-write register file with hardwired zero register and saturating write counter.
// Optional same-cycle write-through to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NUM_RD   = REGFILE_NUM_RD,
  parameter int ZERO_REG = DEPTH - 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [15:0]              wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [15:0]      r_wr_count;
  logic             w_wr_take;

  // Writes aimed at the zero register are dropped and do not count.
  assign w_wr_take = wr_en && (wr_addr != ZERO_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_take) begin
      r_regs[wr_addr] <= wr_data;
      if (r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign wr_count = r_wr_count;

  for (genvar p = 0; p < NUM_RD; p++) begin : gen_rd
    logic [ADDR_W-1:0] w_sel;
    logic [WIDTH-1:0]  w_mux;
    logic [WIDTH-1:0]  w_byp;

    assign w_sel = rd_addr[p*ADDR_W +: ADDR_W];

    read_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_read_mux (
      .i_regs (r_regs),
      .i_sel  (w_sel),
      .o_data (w_mux)
    );

`ifdef REGFILE_BYPASS_EN
    assign w_byp = (w_wr_take && (wr_addr == w_sel)) ? wr_data : w_mux;
`else
    assign w_byp = w_mux;
`endif

    // Zero-forcing overrides bypass; reset also blanks any write-through.
    assign rd_data[p*WIDTH +: WIDTH] = (!reset_n || (w_sel == ZERO_IDX)) ? '0 : w_byp;
  end

endmodule

// File: tb/tb_regfile_nr1w.sv
// Directed bench for regfile_nr1w with four read ports; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_nr1w;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int NR = 4;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*W-1:0]   rd_data;
  logic [15:0]       wr_count;

  int vectors = 0;
  int miscompares = 0;

  regfile_nr1w #(
    .WIDTH  (W),
    .DEPTH  (D),
    .NUM_RD (NR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] port(input int p);
    return rd_data[p*W +: W];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  logic [63:0] byp_exp;

  initial begin
    // Reset: every index on every port reads 0.
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < D; i++) begin
      for (int p = 0; p < NR; p++) set_rd(p, AW'(i));
      #1;
      for (int p = 0; p < NR; p++) chk($sformatf("reset_rd_p%0d_r%0d", p, i), port(p), 64'h0);
    end
    chk("reset_count", 64'(wr_count), 64'h0);

    @(negedge clk);
    reset_n = 1'b1;

    // Basic write/read.
    wr(5'd5, 64'hDEAD_BEEF_0000_0001);
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    chk("basic_rd5", port(0), 64'hDEAD_BEEF_0000_0001);
    chk("basic_rd6", port(1), 64'h0);
    chk("basic_count", 64'(wr_count), 64'd1);

    // Zero register ignores writes and always reads 0.
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    set_rd(2, 5'd31);
    #1;
    chk("xzr_rd", port(2), 64'h0);
    chk("xzr_count", 64'(wr_count), 64'd1);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd31;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    set_rd(0, 5'd31);
    #1;
    chk("xzr_same_cycle", port(0), 64'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("xzr_count2", 64'(wr_count), 64'd1);

    // Same-cycle write and read of reg7.
`ifdef REGFILE_BYPASS_EN
    byp_exp = 64'h1234;
`else
    byp_exp = 64'h0;
`endif
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 64'h1234;
    set_rd(0, 5'd7);
    #1;
    chk("bypass_pre_edge", port(0), byp_exp);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("bypass_post_edge", port(0), 64'h1234);
    chk("bypass_count", 64'(wr_count), 64'd2);

    // Multi-port: reg i = 3*i.
    for (int i = 0; i < 31; i++) wr(AW'(i), 64'(i * 3));
    chk("fill_count", 64'(wr_count), 64'd33);
    set_rd(0, 5'd1);
    set_rd(1, 5'd2);
    set_rd(2, 5'd10);
    set_rd(3, 5'd30);
    #1;
    chk("mp_p0_r1", port(0), 64'd3);
    chk("mp_p1_r2", port(1), 64'd6);
    chk("mp_p2_r10", port(2), 64'd30);
    chk("mp_p3_r30", port(3), 64'd90);
    for (int p = 0; p < NR; p++) set_rd(p, 5'd10);
    #1;
    for (int p = 0; p < NR; p++) chk($sformatf("mp_all10_p%0d", p), port(p), 64'd30);

    // Asynchronous reset between edges.
    wr(5'd2, 64'd9);
    set_rd(0, 5'd2);
    set_rd(1, 5'd3);
    #1;
    chk("pre_areset_rd2", port(0), 64'd9);
    chk("pre_areset_count", 64'(wr_count), 64'd34);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_rd2", port(0), 64'h0);
    chk("areset_count", 64'(wr_count), 64'h0);
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 64'd55;
    #1;
    chk("areset_no_bypass", port(1), 64'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("areset_wr_ignored", port(1), 64'h0);
    chk("areset_count_after", 64'(wr_count), 64'h0);

    // Counter saturation: 65535 + 2 consecutive writes.
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd1;
    wr_data = 64'hABCD;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_count_fffe", 64'(wr_count), 64'hFFFE);
    @(posedge clk);
    #1;
    chk("sat_count_ffff", 64'(wr_count), 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("sat_count_hold", 64'(wr_count), 64'hFFFF);
    set_rd(0, 5'd1);
    #1;
    chk("sat_rd1", port(0), 64'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
